// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared state type, default widths and clog2 helper for the MAC feeder
//   DEF_BATCH/DEF_DATA_W/DEF_RES_W : default lane count, operand width, result width
//   state_t                        : feeder FSM states
//   clog2()                        : ceiling log2, used to derive the adder-tree latency
package mac_feeder_pkg;
   localparam int DEF_BATCH  = 32;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_RES_W  = 24;
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
      return r;
   endfunction
endpackage

// File: rtl/mac_feeder_if.sv
// mac_feeder_if: operand-in and result-out handshake bundle of the MAC feeder
//   cfg_len, in_valid, in_ready, in_a, in_b : operand pair stream and group length
//   res_valid, res_ready, res_vec, res_sca  : captured accumulation result stream
//   master : upstream/downstream side, slave : the feeder
interface mac_feeder_if import mac_feeder_pkg::*; #(
   parameter int BATCH  = DEF_BATCH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RES_W  = DEF_RES_W,
   parameter int LEN_W  = 10
);
   logic [LEN_W-1:0]        cfg_len;
   logic                    in_valid, in_ready;
   logic [BATCH*DATA_W-1:0] in_a, in_b;
   logic                    res_valid, res_ready;
   logic [BATCH*RES_W-1:0]  res_vec;
   logic [RES_W-1:0]        res_sca;
   modport master (output cfg_len, in_valid, in_a, in_b, res_ready,
                   input in_ready, res_valid, res_vec, res_sca);
   modport slave  (input cfg_len, in_valid, in_a, in_b, res_ready,
                   output in_ready, res_valid, res_vec, res_sca);
endinterface

// File: rtl/mac_feeder_drain_ctr.sv
// mac_feeder_drain_ctr: latency timer started on the last issue edge of a group
//   clk, rst    : clock, asynchronous active-low reset
//   load        : last operand pair issues on this edge (edge E)
//   vec_capture : high during the cycle ending at edge E+MAC_LAT
//   sca_capture : high during the cycle ending at edge E+MAC_LAT+TREE_LAT
module mac_feeder_drain_ctr import mac_feeder_pkg::*; #(
   parameter int MAC_LAT  = 3,
   parameter int TREE_LAT = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic vec_capture,
   output logic sca_capture
);
   localparam int TOT = MAC_LAT + TREE_LAT;
   localparam int CW  = clog2(TOT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= load ? CW'(TOT) : (cnt != '0 ? cnt - CW'(1) : cnt);
   // cnt holds TOT+1-k in the cycle ending at edge E+k
   assign vec_capture = cnt == CW'(TREE_LAT + 1);
   assign sca_capture = cnt == CW'(1);
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: groups operand pairs into MAC-array accumulations and returns the captured result
//   clk, rst                  : clock, asynchronous active-low reset
//   bus (mac_feeder_if.slave) : operand stream in, result stream out
//   mac_new_acc, mac_vec_a/b  : registered drive of the MAC array inputs
//   mac_vec_out, mac_sca_out  : MAC array lane accumulators and adder-tree sum
//   perf_ops, perf_stall      : saturating counters, only with MAC_FEEDER_PERF_EN defined
module mac_feeder import mac_feeder_pkg::*; #(
   parameter int BATCH    = DEF_BATCH,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int RES_W    = DEF_RES_W,
   parameter int LEN_W    = 10,
   parameter int MAC_LAT  = 3,
   parameter int TREE_LAT = clog2(BATCH)
) (
   input  logic                    clk,
   input  logic                    rst,
   mac_feeder_if.slave             bus,
   output logic                    mac_new_acc,
   output logic [BATCH*DATA_W-1:0] mac_vec_a,
   output logic [BATCH*DATA_W-1:0] mac_vec_b,
   input  logic [BATCH*RES_W-1:0]  mac_vec_out,
   input  logic [RES_W-1:0]        mac_sca_out,
   output logic [31:0]             perf_ops,
   output logic [31:0]             perf_stall
);
   state_t                 state, state_nx;
   logic [LEN_W-1:0]       rem;
   logic                   in_ready, res_valid, fire, last, feeding, vec_cap, sca_cap;
   logic [BATCH*RES_W-1:0] res_vec;
   logic [RES_W-1:0]       res_sca;
   assign fire          = bus.in_valid & in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_vec   = res_vec;
   assign bus.res_sca   = res_sca;
   always_comb begin
      feeding  = state == IDLE || state == FEED;
      // cfg_len of 0 or 1 both make the first pair the last one
      last     = state == IDLE ? (bus.cfg_len <= LEN_W'(1)) : (rem == LEN_W'(1));
      state_nx = feeding ? (fire ? (last ? DRAIN : FEED) : state) :
                 state == DRAIN ? (sca_cap ? HOLD : DRAIN) :
                 (res_valid && bus.res_ready ? IDLE : HOLD);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         rem         <= '0;
         mac_new_acc <= 1'b0;
         mac_vec_a   <= '0;
         mac_vec_b   <= '0;
         res_valid   <= 1'b0;
         res_vec     <= '0;
         res_sca     <= '0;
      end else begin
         state       <= state_nx;
         in_ready    <= state_nx == IDLE || state_nx == FEED;
         if (fire) rem <= state == IDLE ? bus.cfg_len - LEN_W'(1) : rem - LEN_W'(1);
         // idle edges issue zero operands so the free-running array adds nothing
         mac_new_acc <= fire && state == IDLE;
         mac_vec_a   <= fire ? bus.in_a : '0;
         mac_vec_b   <= fire ? bus.in_b : '0;
         if (vec_cap) res_vec <= mac_vec_out;
         if (sca_cap) res_sca <= mac_sca_out;
         res_valid   <= sca_cap || (res_valid && !bus.res_ready);
      end
   mac_feeder_drain_ctr #(.MAC_LAT(MAC_LAT), .TREE_LAT(TREE_LAT)) u_drain (
      .clk(clk), .rst(rst), .load(fire && last), .vec_capture(vec_cap), .sca_capture(sca_cap)
   );
`ifdef MAC_FEEDER_PERF_EN
   logic [31:0] ops, stall;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ops   <= '0;
         stall <= '0;
      end else begin
         if (fire && ops != '1) ops <= ops + 32'd1;
         if (state == HOLD && !bus.res_ready && stall != '1) stall <= stall + 32'd1;
      end
   assign perf_ops   = ops;
   assign perf_stall = stall;
`else
   assign perf_ops   = '0;
   assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed and random groups against a behavioural MAC array and result model
module tb_mac_feeder;
   import mac_feeder_pkg::*;
   localparam int BATCH = DEF_BATCH, DATA_W = DEF_DATA_W, RES_W = DEF_RES_W, LEN_W = 10;
   localparam int MAC_LAT = 3, TREE_LAT = 5, LAT = MAC_LAT + TREE_LAT;
   localparam int VW = BATCH * DATA_W, RW = BATCH * RES_W;
`ifdef MAC_FEEDER_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic mac_new_acc;
   logic [VW-1:0] mac_vec_a, mac_vec_b;
   logic [RW-1:0] mac_vec_out;
   logic [RES_W-1:0] mac_sca_out;
   logic [31:0] perf_ops, perf_stall;
   int total = 0, bad = 0, cyc = 0, exp_ops = 0, exp_stall = 0;
   logic [VW-1:0] qa[$], qb[$];

   mac_feeder_if #(.BATCH(BATCH), .DATA_W(DATA_W), .RES_W(RES_W), .LEN_W(LEN_W)) bus();
   mac_feeder #(.BATCH(BATCH), .DATA_W(DATA_W), .RES_W(RES_W), .LEN_W(LEN_W),
                .MAC_LAT(MAC_LAT), .TREE_LAT(TREE_LAT)) u_dut (
      .clk(clk), .rst(rst), .bus(bus), .mac_new_acc(mac_new_acc),
      .mac_vec_a(mac_vec_a), .mac_vec_b(mac_vec_b), .mac_vec_out(mac_vec_out),
      .mac_sca_out(mac_sca_out), .perf_ops(perf_ops), .perf_stall(perf_stall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // MAC array model: a product issued at edge E is in the accumulators from edge E+2
   // (sampled by the feeder at E+3) and in the tree sum from edge E+7 (sampled at E+8)
   logic st_new = 1'b0;
   logic [BATCH-1:0][DATA_W-1:0] st_a = '0, st_b = '0;
   logic [BATCH-1:0][RES_W-1:0] acc = '0;
   logic [TREE_LAT-1:0][RES_W-1:0] sca_pipe = '0;
   function automatic logic [RES_W-1:0] lane_sum(input logic [BATCH-1:0][RES_W-1:0] v);
      lane_sum = '0;
      for (int i = 0; i < BATCH; i++) lane_sum += v[i];
   endfunction
   always @(posedge clk) begin
      st_new <= mac_new_acc;
      st_a <= mac_vec_a;
      st_b <= mac_vec_b;
      for (int i = 0; i < BATCH; i++)
         acc[i] <= (st_new ? '0 : acc[i]) + RES_W'(st_a[i]) * RES_W'(st_b[i]);
      sca_pipe <= {sca_pipe[TREE_LAT-2:0], lane_sum(acc)};
   end
   assign mac_vec_out = acc;
   assign mac_sca_out = sca_pipe[TREE_LAT-1];

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] splat(input logic [DATA_W-1:0] v);
      return {BATCH{v}};
   endfunction

   function automatic logic [VW-1:0] rnd_vec();
      for (int i = 0; i < BATCH; i++) rnd_vec[i*DATA_W +: DATA_W] = DATA_W'($urandom);
   endfunction

   task automatic push(input int n, input logic [VW-1:0] a, input logic [VW-1:0] b);
      repeat (n) begin
         qa.push_back(a);
         qb.push_back(b);
      end
   endtask

   task automatic wait_ready(input string tag);
      int w = 0;
      while (bus.in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_rdy"}, bus.in_ready, 1'b1);
   endtask

   // Sends the queued pairs as one group and checks issue, latency, result and handshake
   task automatic do_group(input string tag, input int cfg, input int mid_cfg, input int gap, input int hold);
      logic [BATCH-1:0][RES_W-1:0] ev;
      logic [RES_W-1:0] es;
      int e = 0, n, w;
      n = qa.size();
      ev = '0;
      for (int k = 0; k < n; k++)
         for (int i = 0; i < BATCH; i++)
            ev[i] += RES_W'(qa[k][i*DATA_W +: DATA_W]) * RES_W'(qb[k][i*DATA_W +: DATA_W]);
      es = lane_sum(ev);
      bus.cfg_len = LEN_W'(cfg);
      for (int k = 0; k < n; k++) begin
         wait_ready(tag);
         bus.in_valid = 1'b1;
         bus.in_a = qa[k];
         bus.in_b = qb[k];
         @(negedge clk);
         e = cyc;
         bus.in_valid = 1'b0;
         bus.in_a = '0;
         bus.in_b = '0;
         if (k == 0 && mid_cfg >= 0) bus.cfg_len = LEN_W'(mid_cfg);
         exp_ops++;
         chk({tag, "_vec_a"}, mac_vec_a, qa[k]);
         chk({tag, "_vec_b"}, mac_vec_b, qb[k]);
         chk({tag, "_new_acc"}, mac_new_acc, k == 0);
         chk({tag, "_in_ready"}, bus.in_ready, k < n - 1);
         if (k < n - 1)
            repeat (gap) begin
               @(negedge clk);
               chk({tag, "_gap_a"}, mac_vec_a, '0);
               chk({tag, "_gap_new"}, mac_new_acc, 1'b0);
            end
      end
      w = 0;
      while (bus.res_valid !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_latency"}, cyc - e, LAT);
      chk({tag, "_res_vec"}, bus.res_vec, ev);
      chk({tag, "_res_sca"}, bus.res_sca, es);
      repeat (hold) begin
         @(negedge clk);
         chk({tag, "_hold_vec"}, bus.res_vec, ev);
         chk({tag, "_hold_sca"}, bus.res_sca, es);
         chk({tag, "_hold_valid"}, bus.res_valid, 1'b1);
         chk({tag, "_hold_ready"}, bus.in_ready, 1'b0);
      end
      exp_stall += hold;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk({tag, "_done_valid"}, bus.res_valid, 1'b0);
      chk({tag, "_done_ready"}, bus.in_ready, 1'b1);
      chk({tag, "_perf_ops"}, perf_ops, PERF ? exp_ops : 0);
      chk({tag, "_perf_stall"}, perf_stall, PERF ? exp_stall : 0);
      qa.delete();
      qb.delete();
   endtask

   initial begin
      bus.cfg_len = '0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.res_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_new_acc", mac_new_acc, 1'b0);
      chk("rst_vec_a", mac_vec_a, '0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_vec", bus.res_vec, '0);
      chk("rst_perf_ops", perf_ops, '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push(1, splat(8'd5), splat(8'd7));
      do_group("len1", 1, -1, 0, 0);
      push(4, splat(8'd2), splat(8'd3));
      do_group("len4", 4, -1, 0, 0);
      push(3, splat(8'd2), splat(8'd3));
      do_group("gap3", 3, -1, 2, 10);
      push(1, splat(8'd4), splat(8'd4));
      do_group("cfg0", 0, -1, 0, 0);
      push(4, splat(8'd1), splat(8'd6));
      do_group("mid9", 4, 9, 1, 0);
      bus.cfg_len = LEN_W'(4);
      for (int k = 0; k < 2; k++) begin
         wait_ready("abort");
         bus.in_valid = 1'b1;
         bus.in_a = splat(8'd9);
         bus.in_b = splat(8'd9);
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      chk("abort_in_ready", bus.in_ready, 1'b0);
      chk("abort_new_acc", mac_new_acc, 1'b0);
      chk("abort_vec_a", mac_vec_a, '0);
      chk("abort_vec_b", mac_vec_b, '0);
      chk("abort_res_valid", bus.res_valid, 1'b0);
      chk("abort_res_vec", bus.res_vec, '0);
      chk("abort_res_sca", bus.res_sca, '0);
      chk("abort_perf_ops", perf_ops, '0);
      chk("abort_perf_stall", perf_stall, '0);
      exp_ops = 0;
      exp_stall = 0;
      @(negedge clk);
      rst = 1'b1;
      push(2, splat(8'd1), splat(8'd1));
      do_group("after_rst", 2, -1, 0, 0);
      for (int g = 0; g < 6; g++) begin
         int len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) push(1, rnd_vec(), rnd_vec());
         do_group($sformatf("rnd%0d", g), len, -1, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Sequencing front/back end for the MAC array: accepts a stream of operand-vector pairs over valid/ready and groups them into accumulations of cfg_len pairs.
- Drives the array's operand and new_acc inputs, then waits out the array's fixed pipeline latency.
- Captures the per-lane accumulators and the adder-tree sum into a result register, presented downstream over valid/ready.
- Sits between the operand buffers and the result write-back in the training datapath.

Parameters:
- BATCH, 32, lanes per vector
- DATA_W, 8, operand width
- RES_W, 24, accumulator/result width
- LEN_W, 10, width of cfg_len
- MAC_LAT, 3, edges from an operand issue edge until accum_out includes that product
- TREE_LAT, 5, adder-tree latency in edges (clog2(BATCH))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_len  in  LEN_W  pairs per accumulation; sampled on group start
- in_valid  in  1  operand pair valid
- in_ready  out  1  feeder accepts pair
- in_a  in  BATCH*DATA_W  operand vector A
- in_b  in  BATCH*DATA_W  operand vector B
- mac_new_acc  out  1  to array new_acc (registered)
- mac_vec_a  out  BATCH*DATA_W  to array vec_a (registered)
- mac_vec_b  out  BATCH*DATA_W  to array vec_b (registered)
- mac_vec_out  in  BATCH*RES_W  from array vec_out
- mac_sca_out  in  RES_W  from array sca_out
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_vec  out  BATCH*RES_W  captured lane accumulators
- res_sca  out  RES_W  captured inner-product sum
- perf_ops  out  32  accepted-pair counter (see Optional Feature)
- perf_stall  out  32  result-backpressure cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0 during reset; mac_new_acc=0; mac_vec_a/b=0; res_valid=0; res_vec/res_sca=0; counters=0.
- Acceptance: a pair transfers on an edge where in_valid&in_ready=1. On that same edge mac_vec_a/b<=in_a/in_b; mac_new_acc<=1 for the first pair of a group, else 0.
- Edges with no transfer: mac_vec_a/b<=0 and mac_new_acc<=0, so the array accumulates zero. The array is never stalled.
- States:
  - IDLE: in_ready=1. First transfer latches len=max(cfg_len,1), loads remaining count, sets new_acc. If len=1, go to DRAIN; else go to FEED.
  - FEED: in_ready=1. Each transfer decrements the count. The transfer of the last pair goes to DRAIN. Gaps (in_valid=0) are allowed indefinitely.
  - DRAIN: in_ready=0; drain counter loaded at the last issue edge E.
    - res_vec<=mac_vec_out at edge E+MAC_LAT.
    - res_sca<=mac_sca_out and res_valid<=1 at edge E+MAC_LAT+TREE_LAT; go to HOLD.
  - HOLD: in_ready=0; res_vec/res_sca stable while res_valid=1. On res_valid&res_ready, res_valid<=0 and go to IDLE.
- in_ready is a registered function of state, never combinational from res_ready. Minimum group period = len+MAC_LAT+TREE_LAT+1 cycles.
- Arithmetic: no width change in the feeder. Values pass through unmodified; overflow is the array's concern.
- cfg_len changes mid-group are ignored. cfg_len=0 is treated as 1.
- Reset mid-operation aborts the group and discards any captured result. The array's stale accumulator is harmless because the next group starts with new_acc.

Optional Feature:
- Macro MAC_FEEDER_PERF_EN.
- Defined:
  - perf_ops increments on every accepted pair.
  - perf_stall increments every HOLD cycle with res_ready=0.
  - Both are 32-bit saturating and cleared only by reset.
- Undefined: both ports tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package: state enum (IDLE/FEED/DRAIN/HOLD), default BATCH/DATA_W/RES_W, and a function clog2 for TREE_LAT derivation.
- One natural sub-module: mac_feeder_drain_ctr, the latency timer that loads on E and emits vec_capture/sca_capture strobes.
- FSM and datapath registers stay in the top.

Test Plan:
- len=1, one pair, all lanes a=5, b=7 -> mac_new_acc=1 for one cycle; res_vec lanes=35; res_sca=1120; res_valid at E+8 (default params).
- len=4, all lanes a=2, b=3, back-to-back -> new_acc only on the first issue; lanes=24; res_sca=768.
- len=3 with 2-cycle in_valid gaps between pairs -> zero operands issued in gaps; result identical to the gapless case.
- res_ready held 0 for 10 cycles in HOLD -> res_* stable, in_ready=0, perf_stall=10 (macro on) or 0 (macro off); then handshake -> IDLE, in_ready=1.
- cfg_len=0 -> treated as len=1; cfg_len changed to 9 mid-FEED of a len=4 group -> still exactly 4 pairs consumed.
- rst asserted in FEED after 2 of 4 pairs -> all outputs at reset values immediately; next group of len=2 (a=1, b=1) -> lanes=2, res_sca=64.
